// File: rtl/pipe_mux_if.sv
// pipe_mux_if: handshake and data bundle of the pipe_mux channel selector.
// slave: pipe_mux side. master: producer/consumer side.
// Signals: in_bus, sel, mode, scan_clr, in_valid, in_ready,
//          out_data, out_sel, out_valid, out_ready,
//          out_parity (only with PIPE_MUX_PARITY_EN).
interface pipe_mux_if #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = 4
);
    logic [CHANNELS*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]          sel;
    logic                      mode;
    logic                      scan_clr;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_valid;
    logic                      out_ready;
`ifdef PIPE_MUX_PARITY_EN
    logic                      out_parity;
`endif

    modport slave (
        input  in_bus,
        input  sel,
        input  mode,
        input  scan_clr,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_sel,
        output out_valid
`ifdef PIPE_MUX_PARITY_EN
        , output out_parity
`endif
    );

    modport master (
        output in_bus,
        output sel,
        output mode,
        output scan_clr,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_sel,
        input  out_valid
`ifdef PIPE_MUX_PARITY_EN
        , input out_parity
`endif
    );
endinterface

// File: rtl/pipe_mux.sv
// pipe_mux: one-deep registered channel selector, fixed or round-robin.
// Ports: clk, rst_n (async, active-low), io (pipe_mux_if.slave).
// Optional macro PIPE_MUX_PARITY_EN adds io.out_parity (even parity).
module pipe_mux #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    pipe_mux_if.slave io
);
    logic [WIDTH-1:0] ch [CHANNELS];
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_nxt;
    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] pick;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] sel_q;
    logic             valid_q;
    logic             ready;
    logic             cap;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        assign ch[k] = io.in_bus[k*WIDTH +: WIDTH];
    end

    assign ready = !valid_q || io.out_ready;
    assign cap   = io.in_valid && ready;
    assign pick  = ch[idx];

    // A scan clear replaces the pointer in the same cycle it is seen.
    always_comb begin
        idx = io.sel;
        if (io.mode) begin
            idx = io.scan_clr ? '0 : ptr;
        end
    end

    // Power-of-two channel count makes the +1 wrap for free.
    always_comb begin
        ptr_nxt = ptr;
        if (io.scan_clr) begin
            ptr_nxt = (cap && io.mode) ? SEL_W'(1) : '0;
        end else if (cap && io.mode) begin
            ptr_nxt = ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else if (cap) begin
            data_q  <= pick;
            sel_q   <= idx;
            valid_q <= 1'b1;
        end else if (io.out_ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef PIPE_MUX_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (cap) begin
            par_q <= ^pick;
        end
    end

    assign io.out_parity = par_q;
`endif

    assign io.in_ready  = ready;
    assign io.out_data  = data_q;
    assign io.out_sel   = sel_q;
    assign io.out_valid = valid_q;
endmodule

// File: doc/pipe_mux.md
PIPE_MUX -- requirements
Module: pipe_mux

Interface
REQ-001 Parameter WIDTH, default 1, bit width of each input channel and of out_data.
REQ-002 Parameter CHANNELS, default 16, number of input channels; SHALL be a power of two, 2..16.
REQ-003 Parameter SEL_W, default 4, select width; SHALL equal log2(CHANNELS).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_bus  input  CHANNELS*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 sel  input  SEL_W  channel index used in fixed mode.
REQ-008 mode  input  1  0 = fixed select, 1 = round-robin scan.
REQ-009 scan_clr  input  1  synchronous clear of the scan pointer.
REQ-010 in_valid  input  1  in_bus/sel valid this cycle.
REQ-011 in_ready  output  1  block can accept this cycle.
REQ-012 out_data  output  WIDTH  registered selected channel.
REQ-013 out_sel  output  SEL_W  index that produced out_data.
REQ-014 out_valid  output  1  out_data/out_sel hold a transfer.
REQ-015 out_ready  input  1  downstream accepts this cycle.

Function
REQ-016 in_ready SHALL be combinational: !out_valid || out_ready.
REQ-017 Capture SHALL occur when in_valid && in_ready: out_data <= channel[idx], out_sel <= idx, out_valid <= 1; latency 1 cycle.
REQ-018 idx SHALL be sel when mode=0 and the internal scan pointer ptr when mode=1.
REQ-019 ptr (SEL_W bits) SHALL increment by 1 on each capture with mode=1, wrapping CHANNELS-1 -> 0; ptr SHALL hold when mode=0 or no capture.
REQ-020 scan_clr SHALL take priority over the ptr value: in that cycle idx (mode=1) is 0 and ptr becomes 1 if a capture occurs, else ptr becomes 0.
REQ-021 When out_valid && !out_ready, out_data, out_sel, out_valid and ptr SHALL hold (stall); in_bus changes SHALL NOT affect outputs.
REQ-022 When out_valid && out_ready && !in_valid, out_valid SHALL clear next cycle; out_data/out_sel hold last values.
REQ-023 Simultaneous output accept and new capture SHALL produce back-to-back transfers with no bubble (full throughput).
REQ-024 A mode change SHALL take effect on the next capture; ptr is not reset by a mode change.

Reset
REQ-025 rst_n low SHALL immediately force out_data=0, out_sel=0, out_valid=0, ptr=0, independent of clk.
REQ-026 Reset asserted mid-stall SHALL discard the held transfer; first capture after release uses ptr=0 in mode 1.
REQ-027 in_ready SHALL be 1 during and after reset (out_valid=0).

Configuration
REQ-028 Macro PIPE_MUX_PARITY_EN defined: extra output out_parity (1 bit) SHALL be registered with out_data as even parity (XOR reduction) of the selected channel, reset 0, held on stall.
REQ-029 Macro undefined: port out_parity and its logic SHALL be absent; all other behaviour unchanged.

Verification
REQ-030 Reset then mode=0, sel=5, in_bus channel5=1 (WIDTH=1), in_valid=1, out_ready=1 -> next cycle out_data=1, out_sel=5, out_valid=1.
REQ-031 mode=1, in_valid=1, out_ready=1 for 18 cycles -> out_sel sequence 0,1,...,15,0,1; out_data tracks each channel.
REQ-032 out_valid=1, out_ready=0 for 3 cycles with in_bus toggling -> in_ready=0, outputs and ptr unchanged; out_ready=1 -> capture resumes next cycle.
REQ-033 mode=1, ptr=7, scan_clr=1 with capture -> out_sel=0, following capture out_sel=1.
REQ-034 rst_n pulsed low between clock edges while out_valid=1 -> out_valid=0, out_data=0 immediately; after release mode=1 capture gives out_sel=0.
REQ-035 PIPE_MUX_PARITY_EN defined, WIDTH=8, selected channel 8'hA7 -> out_parity=1 with out_data=8'hA7.
